// File: rtl/status_register.sv
// ============================================================================
//  Module      : status_register
//  Description : 6502-style processor status (P) register with ALU, stack,
//                explicit flag-op and interrupt-entry update paths.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module status_register (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags,
    input  logic       alu_we,
    input  logic [7:0] flag_mask,
    input  logic       pull_we,
    input  logic [7:0] pull_data,
    input  logic [2:0] flag_op,
    input  logic       irq_entry,
    input  logic       instr_done,
    input  logic       push_brk,
    input  logic [2:0] branch_sel,
    output logic [7:0] status,
    output logic [7:0] push_data,
    output logic       irq_mask,
    output logic       branch_taken
);

    localparam int unsigned C_BIT = 0;
    localparam int unsigned Z_BIT = 1;
    localparam int unsigned I_BIT = 2;
    localparam int unsigned D_BIT = 3;
    localparam int unsigned V_BIT = 6;
    localparam int unsigned N_BIT = 7;

    localparam logic [2:0] c_op_clc = 3'd1;
    localparam logic [2:0] c_op_sec = 3'd2;
    localparam logic [2:0] c_op_cli = 3'd3;
    localparam logic [2:0] c_op_sei = 3'd4;
    localparam logic [2:0] c_op_clv = 3'd5;
    localparam logic [2:0] c_op_cld = 3'd6;
    localparam logic [2:0] c_op_sed = 3'd7;

    localparam logic [7:0] c_reset_status = 8'h24;

    logic [7:0] status_q;
    logic [7:0] status_d;
    logic       irq_mask_q;
    logic       irq_mask_d;
    logic       w_sel_flag;
    logic       w_unused;

    // ALU writes first, then flag_op, then irq_entry, so later writers win.
    always_comb begin
        status_d = status_q;
        if (pull_we) begin
            status_d = pull_data;
        end else begin
            if (alu_we) begin
                if (flag_mask[C_BIT]) status_d[C_BIT] = alu_flags[C_BIT];
                if (flag_mask[Z_BIT]) status_d[Z_BIT] = (alu_result == 8'h00);
                if (flag_mask[V_BIT]) status_d[V_BIT] = alu_flags[V_BIT];
                if (flag_mask[N_BIT]) status_d[N_BIT] = alu_result[7];
            end
            case (flag_op)
                c_op_clc: status_d[C_BIT] = 1'b0;
                c_op_sec: status_d[C_BIT] = 1'b1;
                c_op_cli: status_d[I_BIT] = 1'b0;
                c_op_sei: status_d[I_BIT] = 1'b1;
                c_op_clv: status_d[V_BIT] = 1'b0;
                c_op_cld: status_d[D_BIT] = 1'b0;
                c_op_sed: status_d[D_BIT] = 1'b1;
                default:  status_d = status_d;
            endcase
            if (irq_entry) status_d[I_BIT] = 1'b1;
        end
        status_d[5:4] = 2'b10;
    end

    // The mask lags I by one instruction boundary so CLI/SEI act late.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (irq_entry) begin
            irq_mask_d = 1'b1;
        end else if (instr_done) begin
            irq_mask_d = status_q[I_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= c_reset_status;
            irq_mask_q <= 1'b1;
        end else begin
            status_q   <= status_d;
            irq_mask_q <= irq_mask_d;
        end
    end

    always_comb begin
        case (branch_sel[2:1])
            2'b00:   w_sel_flag = status_q[N_BIT];
            2'b01:   w_sel_flag = status_q[V_BIT];
            2'b10:   w_sel_flag = status_q[C_BIT];
            default: w_sel_flag = status_q[Z_BIT];
        endcase
    end

    assign status       = status_q;
    assign irq_mask     = irq_mask_q;
    assign push_data    = {status_q[7:6], 1'b1, push_brk, status_q[3:0]};
    assign branch_taken = (w_sel_flag == branch_sel[0]);

    assign w_unused = ^{alu_flags[5:1], alu_flags[7], flag_mask[5:2], alu_result[6:0]};

endmodule

`default_nettype wire

// File: tb/tb_status_register.sv
// ============================================================================
//  Module      : tb_status_register
//  Description : Directed and randomized bench against a flag-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_status_register;

    logic       clk;
    logic       rst;
    logic [7:0] alu_result;
    logic [7:0] alu_flags;
    logic       alu_we;
    logic [7:0] flag_mask;
    logic       pull_we;
    logic [7:0] pull_data;
    logic [2:0] flag_op;
    logic       irq_entry;
    logic       instr_done;
    logic       push_brk;
    logic [2:0] branch_sel;
    logic [7:0] status;
    logic [7:0] push_data;
    logic       irq_mask;
    logic       branch_taken;

    int compared = 0;
    int mismatched = 0;

    // Reference model: individual flags plus the delayed interrupt mask.
    bit m_c, m_z, m_i, m_d, m_v, m_n, m_mask;

    status_register dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result   (alu_result),
        .alu_flags    (alu_flags),
        .alu_we       (alu_we),
        .flag_mask    (flag_mask),
        .pull_we      (pull_we),
        .pull_data    (pull_data),
        .flag_op      (flag_op),
        .irq_entry    (irq_entry),
        .instr_done   (instr_done),
        .push_brk     (push_brk),
        .branch_sel   (branch_sel),
        .status       (status),
        .push_data    (push_data),
        .irq_mask     (irq_mask),
        .branch_taken (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_p();
        return {m_n, m_v, 1'b1, 1'b0, m_d, m_i, m_z, m_c};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; alu_result = 8'h00; alu_flags = 8'h00; alu_we = 1'b0;
        flag_mask = 8'h00; pull_we = 1'b0; pull_data = 8'h00; flag_op = 3'd0;
        irq_entry = 1'b0; instr_done = 1'b0; push_brk = 1'b0; branch_sel = 3'd0;
    endtask

    // Advance the model by the rules for the currently applied inputs.
    task automatic model_edge();
        bit old_i;
        old_i = m_i;
        if (rst) begin
            {m_c, m_z, m_i, m_d, m_v, m_n} = 6'b001000;
            m_mask = 1'b1;
            return;
        end
        if (pull_we) begin
            m_c = pull_data[0]; m_z = pull_data[1]; m_i = pull_data[2];
            m_d = pull_data[3]; m_v = pull_data[6]; m_n = pull_data[7];
        end else begin
            if (alu_we && flag_mask[0]) m_c = alu_flags[0];
            if (alu_we && flag_mask[1]) m_z = (alu_result == 0);
            if (alu_we && flag_mask[6]) m_v = alu_flags[6];
            if (alu_we && flag_mask[7]) m_n = (alu_result >= 128);
            if (flag_op == 1) m_c = 0;
            if (flag_op == 2) m_c = 1;
            if (flag_op == 3) m_i = 0;
            if (flag_op == 4) m_i = 1;
            if (flag_op == 5) m_v = 0;
            if (flag_op == 6) m_d = 0;
            if (flag_op == 7) m_d = 1;
            if (irq_entry) m_i = 1;
        end
        if (irq_entry) m_mask = 1;
        else if (instr_done) m_mask = old_i;
    endtask

    task automatic comb_check();
        bit flag;
        case (branch_sel[2:1])
            2'd0: flag = m_n;
            2'd1: flag = m_v;
            2'd2: flag = m_c;
            default: flag = m_z;
        endcase
        chk("push_data", push_data, {m_n, m_v, 1'b1, push_brk, m_d, m_i, m_z, m_c});
        chk("branch_taken", {7'd0, branch_taken}, {7'd0, (flag == branch_sel[0])});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("status", status, model_p());
        chk("irq_mask", {7'd0, irq_mask}, {7'd0, m_mask});
    endtask

    initial begin
        idle_inputs();
        m_c = 0; m_z = 0; m_i = 0; m_d = 0; m_v = 0; m_n = 0; m_mask = 0;

        // Reset beats a simultaneous pull.
        rst = 1'b1; pull_we = 1'b1; pull_data = 8'hFF;
        tick();
        chk("rst_over_pull", status, 8'h24);
        chk("rst_irq_mask", {7'd0, irq_mask}, 8'h01);
        idle_inputs();

        alu_we = 1'b1; flag_mask = 8'hC3; alu_result = 8'h00; alu_flags = 8'h01;
        tick();
        chk("alu_zero_carry", status, 8'h27);
        idle_inputs();

        rst = 1'b1; tick(); idle_inputs();
        alu_we = 1'b1; flag_mask = 8'h40; alu_flags = 8'h40; flag_op = 3'd5;
        tick();
        chk("clv_beats_alu", status, 8'h24);
        idle_inputs();

        pull_we = 1'b1; pull_data = 8'hFF; flag_op = 3'd1;
        tick();
        chk("pull_ignores_op", status, 8'hEF);
        idle_inputs();

        tick();
        chk("hold", status, 8'hEF);

        rst = 1'b1; tick(); idle_inputs();
        flag_op = 3'd3; instr_done = 1'b1;
        tick();
        chk("cli_mask_late", {7'd0, irq_mask}, 8'h01);
        idle_inputs();
        instr_done = 1'b1;
        tick();
        chk("cli_mask_now", {7'd0, irq_mask}, 8'h00);
        idle_inputs();
        irq_entry = 1'b1; flag_op = 3'd3;
        tick();
        chk("irq_sets_i", {7'd0, status[2]}, 8'h01);
        chk("irq_sets_mask", {7'd0, irq_mask}, 8'h01);
        idle_inputs();

        pull_we = 1'b1; pull_data = 8'h81;
        tick();
        idle_inputs();
        push_brk = 1'b1; branch_sel = 3'b001;
        #1;
        chk("push_brk", push_data, 8'hB1);
        chk("branch_n_set", {7'd0, branch_taken}, 8'h01);
        comb_check();
        branch_sel = 3'b111;
        #1;
        chk("branch_z_set", {7'd0, branch_taken}, 8'h00);
        comb_check();

        for (int k = 0; k < 400; k++) begin
            rst        = ($urandom_range(0, 31) == 0);
            pull_we    = ($urandom_range(0, 7) == 0);
            pull_data  = 8'($urandom);
            alu_we     = $urandom_range(0, 1) == 1;
            flag_mask  = 8'($urandom);
            alu_result = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            alu_flags  = 8'($urandom);
            flag_op    = 3'($urandom);
            irq_entry  = ($urandom_range(0, 7) == 0);
            instr_done = $urandom_range(0, 2) == 0;
            push_brk   = 1'($urandom);
            branch_sel = 3'($urandom);
            tick();
            comb_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/status_register.md
STATUS_REGISTER -- requirements
Module: status_register

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 alu_result  input  8  ALU result byte, used to derive the Z and N flags.
REQ-005 alu_flags  input  8  ALU flag vector; only the C (bit 0) and V (bit 6) positions are consumed.
REQ-006 alu_we  input  1  strobe to commit the ALU flags selected by flag_mask.
REQ-007 flag_mask  input  8  per-bit update enable; only bits 0 (C), 1 (Z), 6 (V) and 7 (N) are honoured.
REQ-008 pull_we  input  1  PLP/RTI load strobe; pull_data replaces the register.
REQ-009 pull_data  input  8  byte pulled from the stack.
REQ-010 flag_op  input  3  explicit flag operation: 0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
REQ-011 irq_entry  input  1  interrupt/BRK sequence strobe; forces I=1.
REQ-012 instr_done  input  1  one-cycle pulse marking the last cycle of an instruction.
REQ-013 push_brk  input  1  selects the B bit value placed on push_data.
REQ-014 branch_sel  input  3  [2:1] selects the tested flag (00 N, 01 V, 10 C, 11 Z); [0] is the required value.
REQ-015 status  output  8  registered P value: bit 0 C, 1 Z, 2 I, 3 D, 4 B, 5 unused, 6 V, 7 N.
REQ-016 push_data  output  8  byte for PHP/BRK/IRQ pushes (combinational).
REQ-017 irq_mask  output  1  delayed interrupt-disable seen by interrupt logic (registered).
REQ-018 branch_taken  output  1  branch condition result (combinational).

Function
REQ-019 Stored bits SHALL be C, Z, I, D, V and N; status[5] SHALL always read 1 and status[4] SHALL always read 0.
REQ-020 Priority per cycle SHALL be: rst > pull_we > (irq_entry, flag_op, alu_we).
REQ-021 pull_we SHALL load pull_data bits 0-3 and 6-7 and ignore pull_data bits 4-5; alu_we, flag_op and irq_entry SHALL be ignored in that cycle.
REQ-022 On alu_we=1, masked bits SHALL update next edge: C=alu_flags[0]; V=alu_flags[6]; Z=(alu_result==0); N=alu_result[7].
REQ-023 Z and N SHALL always be derived from alu_result; alu_flags bits 1 and 7 SHALL be ignored.
REQ-024 flag_op SHALL update only its target bit, with latency of one edge.
REQ-025 When flag_op and alu_we target the same bit (for example CLV with mask bit 6), flag_op SHALL win.
REQ-026 irq_entry SHALL set I=1 and SHALL override a concurrent CLI.
REQ-027 With alu_we=0, flag_op=0, pull_we=0 and irq_entry=0, the register SHALL hold its value.
REQ-028 push_data SHALL equal {status[7:6], 1, push_brk, status[3:0]}.
REQ-029 branch_taken SHALL be 1 when the selected registered flag equals branch_sel[0].
REQ-030 On an edge where instr_done=1, irq_mask SHALL load the pre-edge status[2], so I changes take effect one instruction later.
REQ-031 On an edge where irq_entry=1, irq_mask SHALL become 1 regardless of instr_done.
REQ-032 In all other cycles, irq_mask SHALL hold its value.

Reset
REQ-033 On rst=1 at an edge, status SHALL become 8'h24 (I=1, bit5=1, all other bits 0) and irq_mask SHALL become 1.
REQ-034 rst SHALL override all other inputs in the same cycle, including pull_we, irq_entry and a partially completed instruction.

Verification
REQ-035 Reset, then alu_we=1, mask=8'hC3, alu_result=8'h00, alu_flags=8'h01 -> status=8'h27.
REQ-036 From 8'h24: alu_we=1, mask=8'h40, alu_flags=8'h40, flag_op=5 (CLV) in the same cycle -> V=0, status=8'h24.
REQ-037 pull_we=1, pull_data=8'hFF, flag_op=1 in the same cycle -> status=8'hEF.
REQ-038 From 8'h24: flag_op=3 (CLI) then instr_done -> irq_mask=1 after that edge; second instr_done -> irq_mask=0; then irq_entry -> status[2]=1 and irq_mask=1 next edge.
REQ-039 status=8'h81, push_brk=1 -> push_data=8'hB1; branch_sel=3'b001 -> branch_taken=1; branch_sel=3'b111 -> branch_taken=0.
REQ-040 rst=1 asserted together with pull_we=1 and pull_data=8'hFF -> status=8'h24 and irq_mask=1.
